// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: sequences multi-cycle data-memory
// accesses, inserts load-use bubbles, squashes wrong-path fetches and freezes on halt.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow; memory-stall entry, load-use, branch and halt checks
// MEM_WAIT | data-memory access in flight; wcnt==0 marks the release cycle
// HALT     | machine frozen, only rst leaves
module pipe_ctrl #(
    parameter int MEM_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ID_rs,
    input  logic [3:0]       ID_rt,
    input  logic             ID_use_rs,
    input  logic             ID_use_rt,
    input  logic             ID_branch_taken,
    input  logic             EX_MemRead,
    input  logic [3:0]       EX_rd,
    input  logic             MEM_MemRead,
    input  logic             MEM_MemWrite,
    input  logic             WB_halt,
    output logic             pc_we,
    output logic             IF_ID_we,
    output logic             ID_EX_we,
    output logic             EX_MEM_we,
    output logic             MEM_WB_we,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             MEM_WB_flush,
    output logic             dmem_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } stateT;

    localparam bit         MEM_STALLS = (MEM_LAT > 1);
    localparam logic [3:0] WAIT_INIT  = 4'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);

    stateT            state, stateNext;
    logic [3:0]       wcnt, wcntNext;
    logic [CNT_W-1:0] stallCnt;
    logic             stallInc;
    logic             memOp;
    logic             hazard;
    logic             memStall;
    logic             normalCycle;

    assign memOp  = MEM_MemRead | MEM_MemWrite;
    assign hazard = EX_MemRead && (EX_rd != 4'd0) &&
                    ((ID_use_rs && (ID_rs == EX_rd)) || (ID_use_rt && (ID_rt == EX_rd)));

    always_comb begin
        stateNext    = state;
        wcntNext     = wcnt;
        stallInc     = 1'b0;
        memStall     = 1'b0;
        normalCycle  = 1'b0;
        pc_we        = 1'b1;
        IF_ID_we     = 1'b1;
        ID_EX_we     = 1'b1;
        EX_MEM_we    = 1'b1;
        MEM_WB_we    = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        MEM_WB_flush = 1'b0;
        dmem_en      = 1'b0;

        case (state)
            RUN: begin
                dmem_en = memOp;
                if (memOp && MEM_STALLS) begin
                    memStall  = 1'b1;
                    stateNext = MEM_WAIT;
                    wcntNext  = WAIT_INIT;
                end else begin
                    normalCycle = 1'b1;
                end
                // An older HLT already in WB wins over anything younger.
                if (WB_halt) stateNext = HALT;
            end
            MEM_WAIT: begin
                dmem_en = memOp;
                if (wcnt != 4'd0) begin
                    memStall = 1'b1;
                    wcntNext = wcnt - 4'd1;
                end else begin
                    normalCycle = 1'b1;
                    stateNext   = WB_halt ? HALT : RUN;
                end
            end
            HALT: begin
                pc_we     = 1'b0;
                IF_ID_we  = 1'b0;
                ID_EX_we  = 1'b0;
                EX_MEM_we = 1'b0;
                MEM_WB_we = 1'b0;
            end
            default: stateNext = RUN;
        endcase

        // Freeze everything upstream of MEM; WB receives a bubble each wait cycle.
        if (memStall) begin
            pc_we        = 1'b0;
            IF_ID_we     = 1'b0;
            ID_EX_we     = 1'b0;
            EX_MEM_we    = 1'b0;
            MEM_WB_flush = 1'b1;
            stallInc     = 1'b1;
        end

        if (normalCycle) begin
            if (hazard) begin
                pc_we       = 1'b0;
                IF_ID_we    = 1'b0;
                ID_EX_flush = 1'b1;
                stallInc    = 1'b1;
            end else if (ID_branch_taken) begin
                IF_ID_flush = 1'b1;
            end
        end

        if (rst) begin
            pc_we        = 1'b0;
            IF_ID_we     = 1'b0;
            ID_EX_we     = 1'b0;
            EX_MEM_we    = 1'b0;
            MEM_WB_we    = 1'b0;
            IF_ID_flush  = 1'b0;
            ID_EX_flush  = 1'b0;
            MEM_WB_flush = 1'b0;
            dmem_en      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wcnt     <= 4'd0;
            stallCnt <= '0;
        end else begin
            state <= stateNext;
            wcnt  <= wcntNext;
            if (stallInc && (stallCnt != {CNT_W{1'b1}}))
                stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign halted    = (state == HALT);
    assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a MEM_LAT=4 instance for the main flow and a
// MEM_LAT=1, 2-bit-counter instance for no-stall memory and counter saturation.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rstS;
    logic [3:0] ID_rs, ID_rt, EX_rd;
    logic       ID_use_rs, ID_use_rt, ID_branch_taken;
    logic       EX_MemRead, MEM_MemRead, MEM_MemWrite, WB_halt;

    logic        pc_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we;
    logic        IF_ID_flush, ID_EX_flush, MEM_WB_flush, dmem_en, halted;
    logic [15:0] stall_cnt;

    logic        sPcWe, sIfIdWe, sIdExWe, sExMemWe, sMemWbWe;
    logic        sIfIdFlush, sIdExFlush, sMemWbFlush, sDmemEn, sHalted;
    logic [1:0]  sStallCnt;

    pipe_ctrl #(.MEM_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
        .ID_branch_taken(ID_branch_taken), .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .WB_halt(WB_halt),
        .pc_we(pc_we), .IF_ID_we(IF_ID_we), .ID_EX_we(ID_EX_we), .EX_MEM_we(EX_MEM_we),
        .MEM_WB_we(MEM_WB_we), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .MEM_WB_flush(MEM_WB_flush), .dmem_en(dmem_en), .halted(halted),
        .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.MEM_LAT(1), .CNT_W(2)) dutSmall (
        .clk(clk), .rst(rstS),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
        .ID_branch_taken(ID_branch_taken), .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .WB_halt(WB_halt),
        .pc_we(sPcWe), .IF_ID_we(sIfIdWe), .ID_EX_we(sIdExWe), .EX_MEM_we(sExMemWe),
        .MEM_WB_we(sMemWbWe), .IF_ID_flush(sIfIdFlush), .ID_EX_flush(sIdExFlush),
        .MEM_WB_flush(sMemWbFlush), .dmem_en(sDmemEn), .halted(sHalted),
        .stall_cnt(sStallCnt)
    );

    wire [4:0] weV   = {pc_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we};
    wire [2:0] flV   = {IF_ID_flush, ID_EX_flush, MEM_WB_flush};
    wire [4:0] sWeV  = {sPcWe, sIfIdWe, sIdExWe, sExMemWe, sMemWbWe};
    wire [2:0] sFlV  = {sIfIdFlush, sIdExFlush, sMemWbFlush};

    int total = 0;
    int bad   = 0;
    int expCnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after the latest input change, then compare.
    task automatic look(input string tag, input logic [4:0] we, input logic [2:0] fl,
                        input logic dm);
        #1;
        check({tag, ".we"}, 32'(weV), 32'(we));
        check({tag, ".flush"}, 32'(flV), 32'(fl));
        check({tag, ".dmem"}, 32'(dmem_en), 32'(dm));
    endtask

    task automatic idle;
        ID_rs = 0; ID_rt = 0; EX_rd = 0;
        ID_use_rs = 0; ID_use_rt = 0; ID_branch_taken = 0;
        EX_MemRead = 0; MEM_MemRead = 0; MEM_MemWrite = 0; WB_halt = 0;
    endtask

    initial begin
        rst = 1; rstS = 1;
        idle();

        // Reset
        tick();
        look("rst_hi", 5'b00000, 3'b000, 1'b0);
        tick();
        rst = 0;
        look("rst_rel", 5'b11111, 3'b000, 1'b0);
        check("rst.halted", 32'(halted), 0);
        check("rst.cnt", 32'(stall_cnt), 0);

        // Load in MEM, MEM_LAT=4: three stall cycles then release
        MEM_MemRead = 1;
        for (int i = 0; i < 3; i++) begin
            look($sformatf("ld_stall%0d", i), 5'b00001, 3'b001, 1'b1);
            tick();
        end
        look("ld_rel", 5'b11111, 3'b000, 1'b1);
        expCnt = 3;
        check("ld_rel.cnt", 32'(stall_cnt), 32'(expCnt));
        tick();
        MEM_MemRead = 0;
        look("ld_after", 5'b11111, 3'b000, 1'b0);
        check("ld.cnt", 32'(stall_cnt), 32'(expCnt));

        // Load-use on rs
        EX_MemRead = 1; EX_rd = 5; ID_rs = 5; ID_use_rs = 1;
        look("lu_rs", 5'b00111, 3'b010, 1'b0);
        tick();
        expCnt++;
        check("lu_rs.cnt", 32'(stall_cnt), 32'(expCnt));

        // Same pattern with destination r0: never a hazard
        EX_rd = 0; ID_rs = 0;
        look("lu_r0", 5'b11111, 3'b000, 1'b0);
        tick();
        check("lu_r0.cnt", 32'(stall_cnt), 32'(expCnt));

        // Load-use on rt; then rt match without use flag
        EX_rd = 7; ID_rs = 3; ID_use_rs = 1; ID_rt = 7; ID_use_rt = 1;
        look("lu_rt", 5'b00111, 3'b010, 1'b0);
        tick();
        expCnt++;
        ID_use_rt = 0;
        look("lu_rt_nouse", 5'b11111, 3'b000, 1'b0);
        tick();
        check("lu_rt.cnt", 32'(stall_cnt), 32'(expCnt));

        // Taken branch with a hazard: bubble only, then squash next cycle
        idle();
        EX_MemRead = 1; EX_rd = 5; ID_rs = 5; ID_use_rs = 1; ID_branch_taken = 1;
        look("br_haz", 5'b00111, 3'b010, 1'b0);
        tick();
        expCnt++;
        EX_MemRead = 0;
        look("br_take", 5'b11111, 3'b100, 1'b0);
        tick();
        check("br.cnt", 32'(stall_cnt), 32'(expCnt));

        // Store in MEM with a pending load-use: memory stall only, bubble on release
        idle();
        MEM_MemWrite = 1; EX_MemRead = 1; EX_rd = 9; ID_rt = 9; ID_use_rt = 1;
        for (int i = 0; i < 3; i++) begin
            look($sformatf("st_stall%0d", i), 5'b00001, 3'b001, 1'b1);
            tick();
        end
        look("st_rel", 5'b00111, 3'b010, 1'b1);
        tick();
        expCnt += 4;
        idle();
        look("st_after", 5'b11111, 3'b000, 1'b0);
        check("st.cnt", 32'(stall_cnt), 32'(expCnt));

        // Back-to-back mem ops: second op stalls right after the first release
        MEM_MemRead = 1;
        for (int i = 0; i < 3; i++) tick();
        look("b2b_rel", 5'b11111, 3'b000, 1'b1);
        tick();
        look("b2b_second", 5'b00001, 3'b001, 1'b1);
        tick(); tick();
        look("b2b_second_last", 5'b00001, 3'b001, 1'b1);
        tick();
        look("b2b_rel2", 5'b11111, 3'b000, 1'b1);
        tick();
        idle();
        expCnt += 6;
        check("b2b.cnt", 32'(stall_cnt), 32'(expCnt));

        // Reset in the middle of MEM_WAIT
        MEM_MemRead = 1;
        tick(); tick();
        rst = 1;
        look("rst_mid", 5'b00000, 3'b000, 1'b0);
        tick();
        rst = 0;
        look("rst_mid_entry", 5'b00001, 3'b001, 1'b1);
        check("rst_mid.cnt", 32'(stall_cnt), 0);
        tick(); tick();
        look("rst_mid_wait", 5'b00001, 3'b001, 1'b1);
        tick();
        look("rst_mid_rel", 5'b11111, 3'b000, 1'b1);
        tick();
        idle();
        check("rst_mid.cnt2", 32'(stall_cnt), 3);

        // Halt: frozen for 10 cycles, even with a mem op present
        WB_halt = 1;
        look("halt_in", 5'b11111, 3'b000, 1'b0);
        check("halt_in.halted", 32'(halted), 0);
        tick();
        WB_halt = 0; MEM_MemRead = 1; EX_MemRead = 1; EX_rd = 2; ID_rs = 2; ID_use_rs = 1;
        for (int i = 0; i < 10; i++) begin
            look($sformatf("halt%0d", i), 5'b00000, 3'b000, 1'b0);
            check($sformatf("halt%0d.halted", i), 32'(halted), 1);
            tick();
        end
        check("halt.cnt", 32'(stall_cnt), 3);
        idle();
        rst = 1;
        tick();
        rst = 0;
        #1;
        check("halt_rst.halted", 32'(halted), 0);
        look("halt_rst", 5'b11111, 3'b000, 1'b0);

        // MEM_LAT=1 instance: memory never stalls; 2-bit counter saturates
        rstS = 0;
        MEM_MemRead = 1;
        #1;
        check("s_mem.we", 32'(sWeV), 32'h1f);
        check("s_mem.flush", 32'(sFlV), 0);
        check("s_mem.dmem", 32'(sDmemEn), 1);
        tick(); tick();
        check("s_mem.cnt", 32'(sStallCnt), 0);
        idle();
        EX_MemRead = 1; EX_rd = 4; ID_rs = 4; ID_use_rs = 1;
        tick(); tick();
        check("s_sat_pre", 32'(sStallCnt), 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("s_sat%0d", i), 32'(sStallCnt), 3);
        end
        check("s.halted", 32'(sHalted), 0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the 5-stage 16-bit pipeline. Drives the write enables and bubble (flush) controls of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It sequences multi-cycle data-memory accesses, detects load-use hazards, squashes the wrong-path fetch on taken branches, and freezes the machine on halt. It also keeps a saturating count of stall cycles for performance reporting.

## Interface
Parameters:
- MEM_LAT, 4: data-memory access latency in cycles, counted from the first cycle the op is in MEM; legal range 1..16.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ID_rs  in  4  source register 1 of the instruction in ID.
- ID_rt  in  4  source register 2 of the instruction in ID.
- ID_use_rs  in  1  ID instruction reads rs.
- ID_use_rt  in  1  ID instruction reads rt.
- ID_branch_taken  in  1  branch in ID resolved taken.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_rd  in  4  destination register of the EX instruction.
- MEM_MemRead  in  1  MEM-stage op is a load.
- MEM_MemWrite  in  1  MEM-stage op is a store.
- WB_halt  in  1  HLT has reached WB.
- pc_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we  out  1 each  register write enables.
- IF_ID_flush, ID_EX_flush, MEM_WB_flush  out  1 each  load a bubble (all-zero controls) instead of d.
- dmem_en  out  1  data-memory enable; address and data stay stable while high.
- halted  out  1  sticky halt indication.
- stall_cnt  out  CNT_W  saturating count of memory and load-use stall cycles.

## Operation
- States: RUN, MEM_WAIT, HALT. Down-counter wcnt (4 bits).
- Outputs are combinational from the state and inputs. Defaults: all *_we=1, all flush=0, dmem_en=0.
- mem_op = MEM_MemRead | MEM_MemWrite. dmem_en = mem_op whenever the state is RUN or MEM_WAIT.
- Memory stall (highest priority):
  - RUN with mem_op and MEM_LAT>1: pc_we, IF_ID_we, ID_EX_we, and EX_MEM_we are 0. MEM_WB_flush=1. wcnt <= MEM_LAT-2. Next state is MEM_WAIT.
  - MEM_WAIT with wcnt!=0: same outputs as the entry cycle; wcnt decrements.
  - MEM_WAIT with wcnt==0: release cycle. Default outputs, so MEM/WB captures the result. Next state is RUN.
  - MEM_LAT==1: mem_op never stalls.
  - Load-use and branch logic are ignored in every stall cycle; nothing is squashed and nothing is bubbled except MEM/WB.
- Load-use (RUN only, no memory stall this cycle):
  - hazard = EX_MemRead & EX_rd!=0 & ((ID_use_rs & ID_rs==EX_rd) | (ID_use_rt & ID_rt==EX_rd)).
  - On hazard: pc_we=0, IF_ID_we=0, ID_EX_flush=1.
  - The hazard is also evaluated in the release cycle.
- Taken branch (RUN or release cycle, no hazard): IF_ID_flush=1 and pc_we=1. If a hazard is present, the branch is ignored that cycle and is re-evaluated after the bubble.
- Halt: WB_halt in RUN, or in the release cycle, moves the state to HALT.
  - In HALT all *_we=0, dmem_en=0, halted=1.
  - HALT is left only by rst.
- stall_cnt increments on each memory-stall cycle (not the release cycle) and each load-use cycle. It saturates at all-ones.

## Timing
- Reset (rst high at a clock edge) sets state=RUN, wcnt=0, stall_cnt=0, halted=0.
- While rst is high, outputs are forced: all *_we=0, flushes=0, dmem_en=0.
- A mem op occupies the MEM stage for exactly MEM_LAT cycles, with MEM_LAT-1 stall cycles. No bubble enters MEM/WB on the release cycle.
- A load-use hazard costs exactly 1 bubble cycle. A taken branch costs 1 squashed fetch.
- Back-to-back mem ops: the release cycle advances the next op into MEM. That op starts its own stall in the following cycle with no idle gap.
- rst asserted mid-MEM_WAIT: state returns to RUN the next cycle and the counters clear. The in-flight access is abandoned.
- halted rises the cycle after WB_halt is sampled.

## Test plan
- Reset check: rst=1 for 2 cycles, then 0 -> halted=0, stall_cnt=0, all *_we=1, dmem_en=0 with no mem op present.
- Load op in MEM with MEM_LAT=4 -> 3 cycles with pc_we=0 and MEM_WB_flush=1, 4th cycle with all we=1. dmem_en high for all 4 cycles. stall_cnt=3.
- EX load with EX_rd=5 and ID_rs=5, ID_use_rs=1 -> one cycle with pc_we=0, IF_ID_we=0, ID_EX_flush=1; stall_cnt +1. Same case with EX_rd=0 -> no stall.
- ID_branch_taken=1 together with a load-use hazard -> bubble only. Next cycle, branch still taken -> IF_ID_flush=1.
- Store in MEM while a load-use hazard is present -> memory stall only, ID_EX_flush=0 throughout. After release, the hazard produces 1 bubble.
- WB_halt=1 -> next cycle halted=1 and all we=0 for 10 cycles. Then rst=1 returns to RUN; preset stall_cnt to 0xFFFE, apply 3 stall cycles -> it reads 0xFFFF.
